// File: rtl/loader_pkg.sv
// Shared definitions for the serial flash loader: FSM state encoding and
// the frame constants used by the loader and anything that talks to it.
package loader_pkg;

   // Loader FSM states, in the order a healthy frame walks through them.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CSUM   = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERR    = 3'd6
   } state_t;

   // First byte of every frame.
   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Instruction memory capacity in 32-bit words (2 KiB of flash).
   localparam int MAX_WORDS = 512;

endpackage

// File: rtl/flash_loader.sv
// Serial boot loader: receives a framed program image one byte at a time,
// assembles little-endian 32-bit words, writes them to instruction memory
// and releases the CPU core from reset once a frame checks out.
//
// Frame: A5, count_lo, count_hi, count*4 data bytes, XOR checksum of data.
// rx_valid is a one-cycle strobe with no back-pressure; bytes may arrive on
// consecutive cycles. flash_en is a one-cycle strobe with no ready; the
// memory must accept a write in the cycle it is presented.
module flash_loader
   import loader_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int ADDR_W  = 11,
   parameter int TIMEOUT = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              flash_en,
   output logic [ADDR_W-1:0] flash_addr,
   output logic [WIDTH-1:0]  flash_data,
   output logic              core_rst,
   output logic              done,
   output logic              error
);

   // Idle counter is wide enough to hold TIMEOUT-1.
   localparam int            TW         = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT - 1);

   state_t              state;
   logic [7:0]          len_lo;
   logic [9:0]          words_left;
   logic [1:0]          byte_idx;
   logic [23:0]         word_buf;
   logic [ADDR_W-1:0]   next_addr;
   logic [7:0]          csum;
   logic [TW-1:0]       idle_cnt;

   logic                frame_active;
   logic                timed_out;
   logic                sync_seen;
   logic [15:0]         len_req;

   // A frame is "open" between the sync byte and the checksum byte; only
   // then does the inter-byte watchdog run.
   assign frame_active = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                         (state == ST_DATA)   || (state == ST_CSUM);

   // A byte arriving in the expiry cycle wins, so rx_valid masks the timeout.
   assign timed_out    = frame_active && !rx_valid && (idle_cnt == IDLE_LIMIT);

   assign sync_seen    = rx_valid && (rx_data == SYNC_BYTE);

   // Full word count, valid while the high length byte is on rx_data.
   assign len_req      = {rx_data, len_lo};

   // Inter-byte idle counter: cleared by every byte and outside a frame.
   always_ff @(posedge clk) begin
      if (rst || !frame_active || rx_valid) begin
         idle_cnt <= '0;
      end else if (idle_cnt != IDLE_LIMIT) begin
         idle_cnt <= idle_cnt + TW'(1);
      end
   end

   // Frame FSM with registered outputs; writes already issued are never undone.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         flash_en   <= 1'b0;
         flash_addr <= '0;
         flash_data <= '0;
         core_rst   <= 1'b1;
         done       <= 1'b0;
         error      <= 1'b0;
         len_lo     <= '0;
         words_left <= '0;
         byte_idx   <= '0;
         word_buf   <= '0;
         next_addr  <= '0;
         csum       <= '0;
      end else begin
         flash_en <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (sync_seen) begin
                  state     <= ST_LEN_LO;
                  next_addr <= '0;
                  csum      <= '0;
                  byte_idx  <= '0;
               end
            end

            ST_LEN_LO: begin
               if (rx_valid) begin
                  len_lo <= rx_data;
                  state  <= ST_LEN_HI;
               end else if (timed_out) begin
                  state <= ST_ERR;
                  error <= 1'b1;
               end
            end

            ST_LEN_HI: begin
               if (rx_valid) begin
                  if (len_req == 16'd0) begin
                     state <= ST_CSUM;
                  end else if (len_req > 16'(MAX_WORDS)) begin
                     state <= ST_ERR;
                     error <= 1'b1;
                  end else begin
                     words_left <= len_req[9:0];
                     state      <= ST_DATA;
                  end
               end else if (timed_out) begin
                  state <= ST_ERR;
                  error <= 1'b1;
               end
            end

            ST_DATA: begin
               if (rx_valid) begin
                  csum <= csum ^ rx_data;
                  if (byte_idx == 2'd3) begin
                     // Fourth byte completes the word: strobe it out next cycle.
                     flash_en   <= 1'b1;
                     flash_addr <= next_addr;
                     flash_data <= WIDTH'({rx_data, word_buf});
                     next_addr  <= next_addr + ADDR_W'(4);
                     byte_idx   <= 2'd0;
                     words_left <= words_left - 10'd1;
                     if (words_left == 10'd1) begin
                        state <= ST_CSUM;
                     end
                  end else begin
                     word_buf[8*byte_idx +: 8] <= rx_data;
                     byte_idx                  <= byte_idx + 2'd1;
                  end
               end else if (timed_out) begin
                  state <= ST_ERR;
                  error <= 1'b1;
               end
            end

            ST_CSUM: begin
               if (rx_valid) begin
                  if (rx_data == csum) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     core_rst <= 1'b0;
                     error    <= 1'b0;
                  end else begin
                     state <= ST_ERR;
                     error <= 1'b1;
                  end
               end else if (timed_out) begin
                  state <= ST_ERR;
                  error <= 1'b1;
               end
            end

            ST_DONE: begin
               // Program is loaded; the core runs until the next system reset.
            end

            ST_ERR: begin
               if (sync_seen) begin
                  state     <= ST_LEN_LO;
                  error     <= 1'b0;
                  next_addr <= '0;
                  csum      <= '0;
                  byte_idx  <= '0;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/flash_loader.md
FLASH_LOADER -- requirements
Module: flash_loader

Interface
REQ-001 Parameter: WIDTH, 32, instruction-memory data width; only 32 is supported.
REQ-002 Parameter: ADDR_W, 11, flash byte-address width; word capacity is 2**ADDR_W/4 = 512.
REQ-003 Parameter: TIMEOUT, 100000, maximum idle cycles between bytes inside a frame.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_valid  input  1  one-cycle strobe, rx_data holds a received byte; back-to-back allowed.
REQ-007 rx_data  input  8  received byte.
REQ-008 flash_en  output  1  one-cycle write strobe to instruction memory.
REQ-009 flash_addr  output  ADDR_W  byte address of the word being written.
REQ-010 flash_data  output  WIDTH  word being written.
REQ-011 core_rst  output  1  holds the CPU core in reset until a load completes.
REQ-012 done  output  1  sticky; last frame loaded with a good checksum.
REQ-013 error  output  1  last frame failed (length, checksum or timeout).

Function
REQ-014 Frame format: sync 0xA5, count_lo, count_hi, then count words (4 bytes each, little-endian), then 1 checksum byte.
REQ-015 States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
REQ-016 IDLE -> LEN_LO on rx_valid with 0xA5; other bytes ignored.
REQ-017 LEN_LO -> LEN_HI on next byte; LEN_HI -> DATA if count is 1..512, -> CSUM if count is 0, -> ERR if count > 512.
REQ-018 Word assembly: byte k of a word lands in bits [8k+7:8k]; word i is written to flash_addr = 4*i, starting at 0.
REQ-019 flash_en is high for exactly one cycle, the cycle after the edge that captures a word's 4th byte; flash_addr and flash_data are valid in that same cycle.
REQ-020 After the last word's write strobe, the state moves to CSUM.
REQ-021 Checksum is the 8-bit XOR of all data bytes only (header excluded); 0x00 when count is 0.
REQ-022 CSUM: match -> DONE, mismatch -> ERR, both on the edge capturing the byte.
REQ-023 DONE: done=1, core_rst=0, error=0 from the following cycle; all further rx_valid is ignored until rst.
REQ-024 ERR: error=1, core_rst=1; 0xA5 clears error and re-enters LEN_LO, restarting the address at 0 and the checksum at 0.
REQ-025 Timeout: in LEN_LO, LEN_HI, DATA or CSUM, TIMEOUT consecutive cycles without rx_valid -> ERR; the counter clears on every rx_valid.
REQ-026 A rx_valid in the same cycle the timeout expires wins: the byte is accepted and no error occurs.
REQ-027 Words already written before an error or reset are not rolled back.
REQ-028 core_rst=1 in every state except DONE.

Reset
REQ-029 rst has priority over all other inputs and aborts any frame mid-operation.
REQ-030 Reset values: state IDLE, flash_en=0, flash_addr=0, flash_data=0, core_rst=1, done=0, error=0, counters=0, checksum=0.

Structure
REQ-031 loader_pkg holds the state enum, the SYNC_BYTE=8'hA5 constant and the MAX_WORDS constant.
REQ-032 Single module; no sub-module. flash_loader instantiates upstream of top and drives top's rst from core_rst ORed with the system rst.

Verification
REQ-033 Frame A5 02 00, words 12345 and 678910, correct checksum -> two strobes: addr 0 data 0x00003039, then addr 4 data 0x000A5BFE; done=1; core_rst=0.
REQ-034 Same frame with a checksum off by one -> both strobes occur; error=1, done=0, core_rst=1.
REQ-035 Frame A5 01 02 (count 513) -> ERR immediately and no flash_en; a subsequent valid frame -> done=1.
REQ-036 Frame A5 00 00 00 -> no strobes; done=1.
REQ-037 Bytes are stalled for TIMEOUT cycles mid-word -> error=1; a stall of TIMEOUT-1 cycles -> no error.
REQ-038 rst is asserted after 3 bytes of a 4-word frame -> outputs return to reset values on the next edge; a fresh frame loads from addr 0.
